// File: rtl/uart_receiver.sv
// 8N1 UART receive front end: two-flop synchronizer, mid-bit sampling FSM,
// first-word-fall-through byte FIFO and sticky framing/overrun flags.
module uart_receiver #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          uart_rx,
    input  logic                          rd_en,
    input  logic                          clr_err,
    output logic [7:0]                    rd_data,
    output logic                          rx_valid,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          frame_err,
    output logic                          overrun,
    output logic [2:0]                    dbg_state
);

    localparam int C    = CLK_FREQ / BAUD;
    localparam int H    = C / 2;
    localparam int CW   = $clog2(C + 1);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = PW + 1;

    localparam logic [CW-1:0]   C_LOAD     = CW'(C);
    localparam logic [CW-1:0]   H_LOAD     = CW'(H);
    localparam logic [CW-1:0]   CNT_ONE    = CW'(1);
    localparam logic [CNTW-1:0] FULL_COUNT = CNTW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    // Handshake: rd_en pops the head byte at the clock edge where it is sampled
    // high together with rx_valid; rd_en while rx_valid is low has no effect.

    logic            rx_meta;
    logic            rx_s;

    state_t          state, state_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic [2:0]      bit_idx, bit_next;
    logic [7:0]      shift, shift_next;
    logic            stop_good;
    logic            stop_bad;
    logic            bit_tick;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CNTW-1:0] count;
    logic            full;
    logic            push;
    logic            pop;
    logic            ov_set;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_idx <= bit_next;
            shift   <= shift_next;
        end
    end

    assign bit_tick = (cnt == CNT_ONE);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        bit_next   = bit_idx;
        shift_next = shift;
        stop_good  = 1'b0;
        stop_bad   = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    cnt_next   = H_LOAD;
                end
            end
            START: begin
                if (bit_tick) begin
                    if (rx_s) begin
                        state_next = IDLE;
                    end else begin
                        state_next = DATA;
                        cnt_next   = C_LOAD;
                        bit_next   = 3'd0;
                    end
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    shift_next = {rx_s, shift[7:1]};
                    cnt_next   = C_LOAD;
                    bit_next   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            STOP: begin
                if (bit_tick) begin
                    if (rx_s) begin
                        stop_good  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        stop_bad   = 1'b1;
                        state_next = WAIT_HIGH;
                    end
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            WAIT_HIGH: begin
                // A held-low line (break) must return high before a new start is hunted.
                if (rx_s) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A pop in the same cycle as a push into a full FIFO frees the slot.
    assign full   = (count == FULL_COUNT);
    assign pop    = rd_en && (count != '0);
    assign push   = stop_good && (!full || pop);
    assign ov_set = stop_good && full && !pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= shift;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (stop_bad) begin
                frame_err <= 1'b1;
            end else if (clr_err) begin
                frame_err <= 1'b0;
            end
            if (ov_set) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
        end
    end

    assign rx_valid  = (count != '0);
    assign rx_count  = count;
    assign rd_data   = rx_valid ? mem[rd_ptr] : 8'h00;
    assign dbg_state = state;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed plus randomized bench for uart_receiver; a byte queue and two flag
// bits model what software should see after every frame and every read.
module tb_uart_receiver;

    localparam int C     = 16;
    localparam int DEPTH = 16;
    localparam logic [2:0] IDLE_CODE = 3'd0;

    logic       clk;
    logic       reset;
    logic       uart_rx;
    logic       rd_en;
    logic       clr_err;
    logic [7:0] rd_data;
    logic       rx_valid;
    logic [4:0] rx_count;
    logic       frame_err;
    logic       overrun;
    logic [2:0] dbg_state;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic       m_fe;
    logic       m_ov;

    uart_receiver #(
        .CLK_FREQ  (1_600_000),
        .BAUD      (100_000),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .uart_rx  (uart_rx),
        .rd_en    (rd_en),
        .clr_err  (clr_err),
        .rd_data  (rd_data),
        .rx_valid (rx_valid),
        .rx_count (rx_count),
        .frame_err(frame_err),
        .overrun  (overrun),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_head();
        return (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'h0;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, "_count"}, 32'(rx_count), 32'(exp_q.size()));
        check({tag, "_valid"}, 32'(rx_valid), 32'(exp_q.size() != 0));
        check({tag, "_data"}, 32'(rd_data), exp_head());
        check({tag, "_fe"}, 32'(frame_err), 32'(m_fe));
        check({tag, "_ov"}, 32'(overrun), 32'(m_ov));
    endtask

    task automatic idle(input int n);
        uart_rx = 1'b1;
        tick(n);
    endtask

    // Drives one frame; optional pop and clr_err are aligned to the push edge,
    // which is the 155th edge after the start bit is driven (2 sync + H + 9C + 1).
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic pop,
                              input logic clr, input string tag);
        logic pop_ok;
        logic set_fe;
        logic set_ov;
        uart_rx = 1'b0;
        tick(C);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            tick(C);
        end
        uart_rx = stop;
        tick(10);
        check({tag, "_pre_count"}, 32'(rx_count), 32'(exp_q.size()));
        pop_ok = pop && (exp_q.size() != 0);
        if (pop_ok) begin
            check({tag, "_pop_head"}, 32'(rd_data), exp_head());
        end
        rd_en   = pop;
        clr_err = clr;
        tick(1);
        rd_en   = 1'b0;
        clr_err = 1'b0;
        set_fe = 1'b0;
        set_ov = 1'b0;
        if (pop_ok) begin
            void'(exp_q.pop_front());
        end
        if (stop) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(d);
            else set_ov = 1'b1;
        end else begin
            set_fe = 1'b1;
        end
        if (clr) begin
            m_fe = set_fe;
            m_ov = set_ov;
        end else begin
            m_fe = m_fe | set_fe;
            m_ov = m_ov | set_ov;
        end
        check_outputs({tag, "_post"});
        tick(5);
    endtask

    task automatic read_byte(input string tag, output logic [7:0] got);
        check({tag, "_rd_valid"}, 32'(rx_valid), 32'(exp_q.size() != 0));
        check({tag, "_rd_data"}, 32'(rd_data), exp_head());
        got = rd_data;
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        check_outputs({tag, "_after_rd"});
    endtask

    task automatic drain(input string tag, output logic [7:0] last);
        logic [7:0] got;
        last = 8'h00;
        while (exp_q.size() != 0) begin
            read_byte(tag, got);
            last = got;
        end
    endtask

    task automatic clear_flags(input string tag);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        m_fe = 1'b0;
        m_ov = 1'b0;
        check({tag, "_fe_clr"}, 32'(frame_err), 32'h0);
        check({tag, "_ov_clr"}, 32'(overrun), 32'h0);
    endtask

    initial begin
        logic [7:0] last;
        logic [7:0] d;
        logic       stop;

        reset   = 1'b0;
        uart_rx = 1'b1;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        m_fe    = 1'b0;
        m_ov    = 1'b0;
        tick(3);
        check_outputs("reset");
        check("reset_state", 32'(dbg_state), 32'(IDLE_CODE));
        reset = 1'b1;
        idle(C);

        // single byte
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, "single");
        read_byte("single", last);
        check("single_value", 32'(last), 32'hA5);

        // glitch rejection
        uart_rx = 1'b0;
        tick(4);
        idle(20);
        check("glitch_state", 32'(dbg_state), 32'(IDLE_CODE));
        check_outputs("glitch");
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, "after_glitch");
        drain("after_glitch", last);
        check("after_glitch_value", 32'(last), 32'h3C);

        // framing error then break
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, "frame_err");
        uart_rx = 1'b0;
        tick(3 * C);
        idle(2 * C);
        check("break_state", 32'(dbg_state), 32'(IDLE_CODE));
        check_outputs("break");
        clear_flags("frame_err");

        // overrun and ordering
        for (int i = 0; i < 17; i++) begin
            send_frame(8'(i), 1'b1, 1'b0, 1'b0, "fill");
        end
        check("overrun_set", 32'(overrun), 32'h1);
        send_frame(8'h11, 1'b1, 1'b0, 1'b1, "clr_vs_ov");
        check("overrun_set_wins", 32'(overrun), 32'h1);
        for (int i = 0; i < 16; i++) begin
            read_byte("order", last);
            check("order_value", 32'(last), 32'(i));
        end
        clear_flags("overrun");

        // full with same-cycle pop
        for (int i = 0; i < 16; i++) begin
            send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0, 1'b0, "fill2");
        end
        send_frame(8'h77, 1'b1, 1'b1, 1'b0, "full_pop");
        check("full_pop_count", 32'(rx_count), 32'd16);
        check("full_pop_no_ov", 32'(overrun), 32'h0);
        drain("full_pop", last);
        check("full_pop_last", 32'(last), 32'h77);

        // randomized frames, pops and clears
        for (int n = 0; n < 12; n++) begin
            d    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 3) != 0);
            send_frame(d, stop, 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0), "rand");
            if (!stop) idle(C);
            idle($urandom_range(0, 8));
        end
        drain("rand", last);
        clear_flags("rand");

        // reset mid-frame with 3 bytes buffered and a sticky flag set
        send_frame(8'h11, 1'b1, 1'b0, 1'b0, "pre_rst");
        send_frame(8'h22, 1'b0, 1'b0, 1'b0, "pre_rst");
        idle(C);
        send_frame(8'h33, 1'b1, 1'b0, 1'b0, "pre_rst");
        send_frame(8'h44, 1'b1, 1'b0, 1'b0, "pre_rst");
        check("pre_rst_count", 32'(rx_count), 32'd3);
        d = 8'hC3;
        uart_rx = 1'b0;
        tick(C);
        for (int i = 0; i < 4; i++) begin
            uart_rx = d[i];
            tick(C);
        end
        uart_rx = d[4];
        tick(8);
        #2;
        reset = 1'b0;
        #1;
        exp_q.delete();
        m_fe = 1'b0;
        m_ov = 1'b0;
        check_outputs("async_rst");
        check("async_rst_state", 32'(dbg_state), 32'(IDLE_CODE));
        uart_rx = 1'b1;
        tick(2);
        reset = 1'b1;
        idle(C);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0, "post_rst");
        check("post_rst_count", 32'(rx_count), 32'd1);
        read_byte("post_rst", last);
        check("post_rst_value", 32'(last), 32'h5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
